mmul_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one montgomery_mul instance among NREQ requesters (e.g. NTT butterfly lanes, twiddle precompute).
- Accepts one operand pair at a time per valid/ready handshake and pulses the multiplier's start.
- Waits for its done, then returns S to the granted requester over a one-hot response handshake.
- Single outstanding operation. Sits directly between requesters and the multiplier's start/A/B/M/M_inv/S/done pins.

---
 rtl/mmul_sched_pkg.sv | 19 +
 rtl/mmul_rr_scheduler_arbiter.sv | 35 +++
 rtl/mmul_rr_scheduler.sv | 134 +++++++++++++
 tb/tb_mmul_rr_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_sched_pkg.sv
// Shared types for the round-robin Montgomery multiplier scheduler.
package mmul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int NREQ_DEFAULT = 4;
  localparam int ID_W         = $clog2(NREQ_DEFAULT);

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmul_rr_scheduler_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after rr_ptr, with wrap.
module rr_arbiter
  import mmul_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = ((int'(rr_ptr) + k) >= NREQ) ? (int'(rr_ptr) + k - NREQ) : (int'(rr_ptr) + k);
      if (enable && !found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IDW'(j);
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mmul_rr_scheduler.sv
// Shares one Montgomery multiplier among NREQ requesters, one operation in flight.
// Optional wait watchdog enabled by defining MMUL_SCHED_TIMEOUT_EN.
module mmul_rr_scheduler
  import mmul_sched_pkg::*;
#(
  parameter int W       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [W-1:0]    cfg_m,
  input  logic [W-1:0]    cfg_m_inv,
  output logic [NREQ-1:0] resp_valid,
  input  logic [NREQ-1:0] resp_ready,
  output logic [W-1:0]    resp_data,
  output logic            resp_err,
  output logic            busy,
  output logic            mm_start,
  output logic [W-1:0]    mm_a,
  output logic [W-1:0]    mm_b,
  output logic [W-1:0]    mm_m,
  output logic [W-1:0]    mm_m_inv,
  input  logic [W-1:0]    mm_s,
  input  logic            mm_done
);

  localparam int IDW = id_width(NREQ);

  state_t          state, state_nx;
  logic [IDW-1:0]  rr_ptr, id, grant_idx;
  logic [NREQ-1:0] grant;
  logic            arb_en, accept, resp_hs, timed_out;
  logic            ld_ops, ld_resp, clr_resp;

  assign arb_en    = (state == IDLE) && !rst;
  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign resp_hs   = resp_ready[id];

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

`ifdef MMUL_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  // Counts WAIT cycles; held at zero elsewhere so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) to_cnt <= '0;
    else                      to_cnt <= to_cnt + CW'(1);
  end

  assign timed_out = (state == WAIT) && (to_cnt == CW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE; else state_nx = IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (mm_done || timed_out) state_nx = RESP; else state_nx = WAIT;
      RESP:    if (resp_hs) state_nx = IDLE; else state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: load/clear strobes for the datapath registers.
  always_comb begin
    ld_ops   = 1'b0;
    ld_resp  = 1'b0;
    clr_resp = 1'b0;
    case (state)
      IDLE:    ld_ops   = accept;
      WAIT:    ld_resp  = mm_done || timed_out;
      RESP:    clr_resp = resp_hs;
      default: ld_ops   = 1'b0;
    endcase
  end

  // Datapath: operands frozen at accept so later cfg/req changes cannot disturb the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      id         <= '0;
      mm_start   <= 1'b0;
      mm_a       <= '0;
      mm_b       <= '0;
      mm_m       <= '0;
      mm_m_inv   <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mm_start <= (state_nx == ISSUE);
      busy     <= (state_nx != IDLE);
      if (ld_ops) begin
        mm_a     <= req_a[grant_idx*W +: W];
        mm_b     <= req_b[grant_idx*W +: W];
        mm_m     <= cfg_m;
        mm_m_inv <= cfg_m_inv;
        id       <= grant_idx;
        rr_ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
      if (ld_resp) begin
        resp_valid <= NREQ'(1) << id;
        resp_data  <= mm_done ? mm_s : '0;
        resp_err   <= ~mm_done;
      end else if (clr_resp) begin
        resp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mmul_rr_scheduler.sv
// Directed self-checking bench for mmul_rr_scheduler with a 5-cycle stub multiplier (mm_s = A + B).
module tb_mmul_rr_scheduler;

  localparam int W    = 32;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]    cfg_m, cfg_m_inv, resp_data;
  logic            resp_err, busy, mm_start, mm_done;
  logic [W-1:0]    mm_a, mm_b, mm_m, mm_m_inv, mm_s;

  logic            stub_hang  = 1'b0;
  logic            force_done = 1'b0;
  int              scnt;
  int              tests  = 0;
  int              failed = 0;

  always #5 clk = ~clk;

  mmul_rr_scheduler #(.W(W), .NREQ(NREQ), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .cfg_m(cfg_m), .cfg_m_inv(cfg_m_inv),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_m_inv(mm_m_inv),
    .mm_s(mm_s), .mm_done(mm_done)
  );

  // Stub multiplier: done is high in the 5th cycle after the start cycle.
  always @(posedge clk) begin
    if (rst)                         scnt <= 0;
    else if (mm_start)               scnt <= 1;
    else if (scnt != 0 && scnt != 5) scnt <= scnt + 1;
    else                             scnt <= 0;
  end
  assign mm_done = ((scnt == 5) || force_done) && !stub_hang;
  assign mm_s    = mm_a + mm_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (resp_valid == '0 && n < 20) begin
      tick();
      n++;
    end
    check("resp_wait_bound", 64'(n < 20), 64'd1);
  endtask

  initial begin
    int e;
    rst = 1'b1; req_valid = 4'b1111; resp_ready = '0;
    req_a = '0; req_b = '0; cfg_m = '0; cfg_m_inv = '0;
    tick();
    tick();
    // Reset values
    check("rst_req_ready", req_ready, 0);
    check("rst_mm_start", mm_start, 0);
    check("rst_mm_a", mm_a, 0);
    check("rst_mm_m", mm_m, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_busy", busy, 0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Single request on requester 0
    resp_ready = 4'b1111; cfg_m = 32'd7681; cfg_m_inv = 32'd255;
    set_ops(0, 32'd6914, 32'd1);
    req_valid = 4'b0001;
    #1;
    check("single_req_ready", req_ready, 4'b0001);
    tick();
    check("single_start", mm_start, 1);
    check("single_mm_a", mm_a, 6914);
    check("single_mm_b", mm_b, 1);
    check("single_mm_m", mm_m, 7681);
    check("single_mm_m_inv", mm_m_inv, 255);
    check("single_busy", busy, 1);
    check("single_ready_busy", req_ready, 0);
    req_valid = '0; cfg_m = 32'd1234; cfg_m_inv = 32'd99;
    tick();
    check("single_start_pulse", mm_start, 0);
    repeat (4) tick();
    check("single_no_resp_early", resp_valid, 0);
    check("single_m_stable", mm_m, 7681);
    check("single_minv_stable", mm_m_inv, 255);
    tick();
    check("single_resp_valid", resp_valid, 4'b0001);
    check("single_resp_data", resp_data, 6915);
    check("single_resp_err", resp_err, 0);
    tick();
    check("single_resp_clear", resp_valid, 0);
    check("single_idle_busy", busy, 0);

    // Contention: all four valid from reset release
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_ops(i, W'(i), 32'd100);
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      e = k % NREQ;
      check("cont_grant", req_ready, 64'(4'b0001 << e));
      tick();
      wait_resp();
      check("cont_resp_valid", resp_valid, 64'(4'b0001 << e));
      check("cont_resp_data", resp_data, 64'(100 + e));
      tick();
    end
    req_valid = '0;

    // mm_done while idle must be ignored
    force_done = 1'b1;
    tick();
    tick();
    force_done = 1'b0;
    check("idle_done_resp", resp_valid, 0);
    check("idle_done_busy", busy, 0);

    // Fairness: requesters 1 and 3
    set_ops(1, 32'd5, 32'd6); set_ops(3, 32'd7, 32'd8);
    req_valid = 4'b1010;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 1 : 3;
      check("fair_grant", req_ready, 64'(4'b0001 << e));
      tick();
      wait_resp();
      check("fair_resp_valid", resp_valid, 64'(4'b0001 << e));
      check("fair_resp_data", resp_data, (e == 1) ? 64'd11 : 64'd15);
      tick();
    end
    req_valid = '0;

    // Backpressure on requester 0; other resp_ready bits are ignored
    reset_dut();
    resp_ready = 4'b0000;
    set_ops(0, 32'd10, 32'd20); set_ops(1, 32'd1, 32'd2);
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = 4'b0010;
    wait_resp();
    check("bp_resp_valid", resp_valid, 4'b0001);
    check("bp_resp_data", resp_data, 30);
    resp_ready = 4'b1110;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_hold_valid", resp_valid, 4'b0001);
      check("bp_hold_data", resp_data, 30);
      check("bp_hold_busy", busy, 1);
      check("bp_hold_ready", req_ready, 0);
    end
    resp_ready = 4'b0001;
    tick();
    check("bp_release_valid", resp_valid, 0);
    check("bp_next_grant", req_ready, 4'b0010);
    resp_ready = 4'b1111;
    tick();
    req_valid = '0;
    wait_resp();
    check("bp_next_valid", resp_valid, 4'b0010);
    check("bp_next_data", resp_data, 3);
    tick();

    // Reset two cycles after mm_start
    set_ops(0, 32'd40, 32'd2);
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    check("rmw_start", mm_start, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmw_mm_start", mm_start, 0);
    check("rmw_mm_a", mm_a, 0);
    check("rmw_mm_b", mm_b, 0);
    check("rmw_busy", busy, 0);
    check("rmw_resp_valid", resp_valid, 0);
    check("rmw_resp_data", resp_data, 0);
    check("rmw_req_ready", req_ready, 0);
    repeat (10) tick();
    check("rmw_no_resp", resp_valid, 0);

`ifdef MMUL_SCHED_TIMEOUT_EN
    // Watchdog: stub never completes
    stub_hang = 1'b1;
    resp_ready = 4'b0000;
    set_ops(2, 32'd3, 32'd4);
    req_valid = 4'b0100;
    #1;
    tick();
    req_valid = '0;
    repeat (64) tick();
    check("to_not_yet", resp_valid, 0);
    tick();
    check("to_resp_valid", resp_valid, 4'b0100);
    check("to_resp_err", resp_err, 1);
    check("to_resp_data", resp_data, 0);
    resp_ready = 4'b0100;
    tick();
    check("to_release", resp_valid, 0);
    stub_hang = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
